// File: rtl/cpu_pkg.sv
// Shared encodings for the decode/execute boundary: ALU op classes, R-type funct codes and
// the ALU's 3-bit control codes.
package cpu_pkg;

    localparam logic [2:0] ALU_CTRL_ADD = 3'b010;
    localparam logic [2:0] ALU_CTRL_SUB = 3'b110;
    localparam logic [2:0] ALU_CTRL_AND = 3'b000;
    localparam logic [2:0] ALU_CTRL_OR  = 3'b001;
    localparam logic [2:0] ALU_CTRL_NOR = 3'b011;
    localparam logic [2:0] ALU_CTRL_SLT = 3'b111;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_ORI   = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decoder: (alu_op, funct) -> 3-bit ALU control code plus a flag
// for an R-type funct that is not recognised.
module alu_ctrl_dec
    import cpu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       illegal
);

    always_comb begin
        alu_ctrl = ALU_CTRL_ADD;
        illegal  = 1'b0;
        case (alu_op)
            ALU_OP_ADD: alu_ctrl = ALU_CTRL_ADD;
            ALU_OP_SUB: alu_ctrl = ALU_CTRL_SUB;
            ALU_OP_ORI: alu_ctrl = ALU_CTRL_OR;
            default: begin
                case (funct)
                    FUNCT_ADD: alu_ctrl = ALU_CTRL_ADD;
                    FUNCT_SUB: alu_ctrl = ALU_CTRL_SUB;
                    FUNCT_AND: alu_ctrl = ALU_CTRL_AND;
                    FUNCT_OR:  alu_ctrl = ALU_CTRL_OR;
                    FUNCT_NOR: alu_ctrl = ALU_CTRL_NOR;
                    FUNCT_SLT: alu_ctrl = ALU_CTRL_SLT;
                    default:   illegal  = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand select, writeback bypass and ALU control decode.
// Define ID_EX_ILLEGAL_TRAP_EN to add illegal_o and suppress writes of unknown R-type ops.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0]     rs_data,
    input  logic [DATA_W-1:0]     rt_data,
    input  logic [15:0]           imm16,
    input  logic [1:0]            alu_op,
    input  logic [5:0]            funct,
    input  logic                  alu_src,
    input  logic                  reg_dst,
    input  logic                  reg_write,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  mem_to_reg,
    input  logic                  branch,
    input  logic                  flush,
    input  logic                  wb1_en,
    input  logic [REG_ADDR_W-1:0] wb1_addr,
    input  logic [DATA_W-1:0]     wb1_data,
    input  logic                  wb2_en,
    input  logic [REG_ADDR_W-1:0] wb2_addr,
    input  logic [DATA_W-1:0]     wb2_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     op1,
    output logic [DATA_W-1:0]     op2,
    output logic [2:0]            alu_ctrl,
    output logic [DATA_W-1:0]     store_data,
    output logic [REG_ADDR_W-1:0] dest_addr,
    output logic                  reg_write_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic                  mem_to_reg_o,
    output logic                  branch_o
`ifdef ID_EX_ILLEGAL_TRAP_EN
    ,
    output logic                  illegal_o
`endif
);

    logic                  valid_q;
    logic [REG_ADDR_W-1:0] rs_addr_q, rt_addr_q, dest_q;
    logic [DATA_W-1:0]     rs_val_q, rt_val_q, imm_q;
    logic                  alu_src_q;
    logic [2:0]            ctrl_q;
    logic                  reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q, branch_q;

    logic [2:0]            dec_ctrl;
    logic                  dec_illegal;
    logic                  trap;
    logic                  capture;
    logic [DATA_W-1:0]     imm_ext;

    alu_ctrl_dec u_dec (
        .alu_op   (alu_op),
        .funct    (funct),
        .alu_ctrl (dec_ctrl),
        .illegal  (dec_illegal)
    );

`ifdef ID_EX_ILLEGAL_TRAP_EN
    logic illegal_q;
    assign trap      = dec_illegal;
    assign illegal_o = illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (flush) begin
            illegal_q <= 1'b0;
        end else if (capture) begin
            illegal_q <= dec_illegal;
        end
    end
`else
    logic unused_illegal;
    assign trap           = 1'b0;
    assign unused_illegal = dec_illegal;
`endif

    // Register 0 is hard-wired, so it never takes forwarded data; wb1 is the younger result.
    function automatic logic [DATA_W-1:0] bypass(input logic [REG_ADDR_W-1:0] addr,
                                                 input logic [DATA_W-1:0]     base);
        if (addr == '0)                  return base;
        else if (wb1_en && wb1_addr == addr) return wb1_data;
        else if (wb2_en && wb2_addr == addr) return wb2_data;
        else                             return base;
    endfunction

    assign in_ready = !valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;
    assign imm_ext  = (alu_op == ALU_OP_ORI) ? DATA_W'(imm16)
                                             : DATA_W'(signed'(imm16));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            rs_addr_q    <= '0;
            rt_addr_q    <= '0;
            dest_q       <= '0;
            rs_val_q     <= '0;
            rt_val_q     <= '0;
            imm_q        <= '0;
            alu_src_q    <= 1'b0;
            ctrl_q       <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            branch_q     <= 1'b0;
        end else if (flush) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
        end else if (capture) begin
            valid_q      <= 1'b1;
            rs_addr_q    <= rs_addr;
            rt_addr_q    <= rt_addr;
            dest_q       <= reg_dst ? rd_addr : rt_addr;
            rs_val_q     <= bypass(rs_addr, rs_data);
            rt_val_q     <= bypass(rt_addr, rt_data);
            imm_q        <= imm_ext;
            alu_src_q    <= alu_src;
            ctrl_q       <= dec_ctrl;
            reg_write_q  <= reg_write && !trap;
            mem_read_q   <= mem_read;
            mem_write_q  <= mem_write && !trap;
            mem_to_reg_q <= mem_to_reg;
            branch_q     <= branch;
        end else if (in_ready) begin
            valid_q <= 1'b0;
        end else begin
            // Stalled: keep picking up results for the held sources until execute accepts.
            rs_val_q <= bypass(rs_addr_q, rs_val_q);
            rt_val_q <= bypass(rt_addr_q, rt_val_q);
        end
    end

    assign out_valid    = valid_q;
    assign op1          = rs_val_q;
    assign op2          = alu_src_q ? imm_q : rt_val_q;
    assign store_data   = rt_val_q;
    assign alu_ctrl     = ctrl_q;
    assign dest_addr    = dest_q;
    assign reg_write_o  = reg_write_q;
    assign mem_read_o   = mem_read_q;
    assign mem_write_o  = mem_write_q;
    assign mem_to_reg_o = mem_to_reg_q;
    assign branch_o     = branch_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios then randomized traffic, all
// compared against an instruction-level reference model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [31:0] rs_data, rt_data;
    logic [15:0] imm16;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic        alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg, branch, flush;
    logic        wb1_en, wb2_en;
    logic [4:0]  wb1_addr, wb2_addr;
    logic [31:0] wb1_data, wb2_data;
    logic        out_valid, out_ready;
    logic [31:0] op1, op2, store_data;
    logic [2:0]  alu_ctrl;
    logic [4:0]  dest_addr;
    logic        reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, branch_o;
`ifdef ID_EX_ILLEGAL_TRAP_EN
    logic        illegal_o;
`endif

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .rs_data(rs_data), .rt_data(rt_data), .imm16(imm16), .alu_op(alu_op),
        .funct(funct), .alu_src(alu_src), .reg_dst(reg_dst), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .branch(branch), .flush(flush),
        .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
        .wb2_en(wb2_en), .wb2_addr(wb2_addr), .wb2_data(wb2_data),
        .out_valid(out_valid), .out_ready(out_ready), .op1(op1), .op2(op2),
        .alu_ctrl(alu_ctrl), .store_data(store_data), .dest_addr(dest_addr),
        .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_to_reg_o(mem_to_reg_o), .branch_o(branch_o)
`ifdef ID_EX_ILLEGAL_TRAP_EN
        , .illegal_o(illegal_o)
`endif
    );

    always #5 clk = ~clk;

    // One instruction as execute should see it.
    typedef struct {
        bit          valid;
        bit [4:0]    rs_a, rt_a, dest;
        bit [31:0]   rs, rt, imm;
        bit          use_imm;
        bit [2:0]    ctrl;
        bit          rw, mr, mw, mtr, br, ill;
    } instr_t;

    instr_t m;
    int     n_vec = 0;
    int     n_err = 0;
    int     n_xfer = 0;
    int     x0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] fwd(input bit [4:0] a, input bit [31:0] base);
        if (a != 0 && wb1_en && wb1_addr == a) return wb1_data;
        if (a != 0 && wb2_en && wb2_addr == a) return wb2_data;
        return base;
    endfunction

    function automatic bit [2:0] ref_ctrl(input bit [1:0] op, input bit [5:0] f,
                                          output bit bad);
        bad = 0;
        if (op == 2'd0) return 3'd2;
        if (op == 2'd1) return 3'd6;
        if (op == 2'd3) return 3'd1;
        case (f)
            6'd32: return 3'd2;
            6'd34: return 3'd6;
            6'd36: return 3'd0;
            6'd37: return 3'd1;
            6'd39: return 3'd3;
            6'd42: return 3'd7;
            default: begin bad = 1; return 3'd2; end
        endcase
    endfunction

    task automatic check_outputs();
        chk("out_valid", out_valid, m.valid);
        if (m.valid) begin
            chk("op1", op1, m.rs);
            chk("op2", op2, m.use_imm ? m.imm : m.rt);
            chk("store_data", store_data, m.rt);
            chk("alu_ctrl", alu_ctrl, m.ctrl);
            chk("dest_addr", dest_addr, m.dest);
            chk("ctl", {reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, branch_o},
                {m.rw, m.mr, m.mw, m.mtr, m.br});
`ifdef ID_EX_ILLEGAL_TRAP_EN
            chk("illegal_o", illegal_o, m.ill);
`endif
        end
    endtask

    // Inputs are already driven; advance one clock and compare.
    task automatic cycle();
        bit rdy, bad;
        #1;
        rdy = !m.valid || out_ready;
        chk("in_ready", in_ready, rdy);
        if (out_valid && out_ready) n_xfer++;
        if (flush) begin
            m.valid = 0; m.rw = 0; m.mw = 0; m.ill = 0;
        end else if (in_valid && rdy) begin
            m.valid   = 1;
            m.rs_a    = rs_addr;
            m.rt_a    = rt_addr;
            m.rs      = fwd(rs_addr, rs_data);
            m.rt      = fwd(rt_addr, rt_data);
            m.dest    = reg_dst ? rd_addr : rt_addr;
            m.use_imm = alu_src;
            if (alu_op == 2'd3 || imm16 < 16'h8000) m.imm = {16'h0, imm16};
            else m.imm = 32'hFFFF_0000 + imm16;
            m.ctrl = ref_ctrl(alu_op, funct, bad);
`ifdef ID_EX_ILLEGAL_TRAP_EN
            m.ill = bad;
`else
            bad = 0;
`endif
            m.rw = reg_write && !bad; m.mr = mem_read; m.mw = mem_write && !bad;
            m.mtr = mem_to_reg; m.br = branch;
        end else if (rdy) begin
            m.valid = 0;
        end else begin
            m.rs = fwd(m.rs_a, m.rs);
            m.rt = fwd(m.rt_a, m.rt);
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic quiet();
        {in_valid, alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg} = '0;
        {branch, flush, wb1_en, wb2_en} = '0;
        {rs_addr, rt_addr, rd_addr, wb1_addr, wb2_addr} = '0;
        {rs_data, rt_data, wb1_data, wb2_data} = '0;
        imm16 = 0; alu_op = 0; funct = 0; out_ready = 1;
    endtask

    task automatic randomize_inputs();
        bit [5:0] fl [7];
        fl = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd63};
        in_valid  = $urandom_range(0, 3) != 0;
        out_ready = $urandom_range(0, 9) < 7;
        flush     = $urandom_range(0, 15) == 0;
        rs_addr = $urandom_range(0, 3); rt_addr = $urandom_range(0, 3);
        rd_addr = $urandom; rs_data = $urandom; rt_data = $urandom;
        imm16 = $urandom; alu_op = $urandom; alu_src = $urandom; reg_dst = $urandom;
        funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fl[$urandom_range(0, 6)];
        {reg_write, mem_read, mem_write, mem_to_reg, branch} = 5'($urandom);
        wb1_en = $urandom; wb1_addr = $urandom_range(0, 3); wb1_data = $urandom;
        wb2_en = $urandom; wb2_addr = $urandom_range(0, 3); wb2_data = $urandom;
    endtask

    initial begin
        bit [5:0] fn [3];
        bit [2:0] ce [3];
        fn = '{6'b101010, 6'b100111, 6'b100010};
        ce = '{3'b111, 3'b011, 3'b110};
        m = '{default: 0};
        quiet();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin randomize_inputs(); cycle(); end

        // Asynchronous reset in the middle of traffic.
        in_valid = 1; out_ready = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_op1", op1, 0);
        chk("rst_op2", op2, 0);
        chk("rst_alu_ctrl", alu_ctrl, 0);
        chk("rst_ctl", {reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, branch_o}, 0);
        m = '{default: 0};
        @(negedge clk);
        rst_n = 1'b1;
        quiet();

        in_valid = 1; rs_addr = 1; rs_data = 5; rt_addr = 2; rt_data = 7;
        cycle();
        chk("add_op1", op1, 5); chk("add_op2", op2, 7); chk("add_ctrl", alu_ctrl, 3'b010);

        for (int i = 0; i < 3; i++) begin
            alu_op = 2'b10; funct = fn[i];
            cycle();
            chk("funct_ctrl", alu_ctrl, ce[i]);
        end

        alu_src = 1; imm16 = 16'hFFFE; alu_op = 2'b00;
        cycle();
        chk("imm_sext", op2, 32'hFFFF_FFFE);
        alu_op = 2'b11;
        cycle();
        chk("imm_zext", op2, 32'h0000_FFFE);
        alu_src = 0; alu_op = 0;

        rs_addr = 3; rs_data = 32'h11;
        wb1_en = 1; wb1_addr = 3; wb1_data = 32'hAA;
        wb2_en = 1; wb2_addr = 3; wb2_data = 32'hBB;
        cycle();
        chk("byp_wb1_prio", op1, 32'hAA);
        rs_addr = 0; rs_data = 32'h22; wb1_addr = 0; wb2_addr = 0;
        cycle();
        chk("byp_r0", op1, 32'h22);
        quiet();

        // Stall with a late writeback to the held rt.
        in_valid = 1; rt_addr = 4; rt_data = 32'h10;
        cycle();
        x0 = n_xfer;
        out_ready = 0; rt_addr = 6; rt_data = 32'h99;
        cycle();
        wb2_en = 1; wb2_addr = 4; wb2_data = 32'h55;
        cycle();
        wb2_en = 0;
        cycle();
        chk("stall_op2", op2, 32'h55);
        chk("stall_in_ready", in_ready, 0);
        out_ready = 1;
        #1 chk("release_in_ready", in_ready, 1);
        cycle();
        chk("stall_xfers", n_xfer - x0, 1);

        // Flush a full stage while a new instruction is offered.
        quiet();
        in_valid = 1; reg_write = 1; mem_write = 1;
        cycle();
        out_ready = 0; flush = 1;
        x0 = n_xfer;
        cycle();
        chk("flush_valid", out_valid, 0);
        chk("flush_rw", reg_write_o, 0);
        quiet();
        cycle();
        chk("flush_xfers", n_xfer - x0, 0);

        in_valid = 1; alu_op = 2'b10; funct = 6'b111111; reg_write = 1;
        cycle();
`ifdef ID_EX_ILLEGAL_TRAP_EN
        chk("trap_illegal", illegal_o, 1);
        chk("trap_rw", reg_write_o, 0);
`else
        chk("unk_ctrl", alu_ctrl, 3'b010);
        chk("unk_rw", reg_write_o, 1);
`endif

        repeat (400) begin randomize_inputs(); cycle(); end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
